fifo_access_sched: RTL and testbench
====================================

Name: fifo_access_sched

Overview:
- Scheduler in front of one sync FIFO. The FIFO accepts either one write or one read per cycle, and a write wins when both are presented.
- Shares the FIFO write port between N producers using round-robin arbitration, and interleaves a single consumer's reads under a bounded-burst fairness policy.
- Tracks FIFO occupancy with a shadow counter, so commands to the FIFO are never illegal (no write when full, no read when empty) and the FIFO's error_o never fires.
- Sits between producer/consumer logic and the FIFO instance; drives all FIFO control pins, including the FIFO's reset.

Parameters:
- N_REQ, 4, number of write requesters (2..8).
- DEPTH, 16, FIFO depth; must match the attached FIFO.
- WIDTH, 4, data width; must match the attached FIFO.
- WR_BURST, 4, max consecutive write grants while a read is pending (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-producer write request.
- wdata_i  in  N_REQ*WIDTH  producer data; slice k = [k*WIDTH +: WIDTH].
- gnt_o  out  N_REQ  one-hot write accept, combinational; transfer occurs when req_i[k] & gnt_o[k].
- rd_req_i  in  1  consumer read request.
- rd_gnt_o  out  1  read accept, combinational.
- rd_valid_o  out  1  rd_data_o valid, one-cycle pulse.
- rd_data_o  out  WIDTH  read data (passthrough of fifo_rdata_i).
- fifo_rst_o  out  1  active-high sync reset to the FIFO.
- fifo_wr_en_o  out  1  registered FIFO write enable.
- fifo_wdata_o  out  WIDTH  registered FIFO write data.
- fifo_rd_en_o  out  1  registered FIFO read enable.
- fifo_rdata_i  in  WIDTH  FIFO rdata_o.
- fifo_full_i  in  1  FIFO full_o.
- fifo_empty_i  in  1  FIFO empty_o.
- level_o  out  $clog2(DEPTH+1)  shadow occupancy.

Behaviour:
- Reset (rst_ni low, async):
  - All registered outputs 0; level_o=0; round-robin pointer=0; state IDLE; burst count 0.
  - fifo_rst_o=1 while in reset and for exactly 1 cycle after release.
  - No grants while fifo_rst_o=1.
- Shadow count:
  - cnt increments on write accept, decrements on read accept, updated at the accept edge; never both in one cycle.
  - Write legal iff cnt<DEPTH; read legal iff cnt>0.
  - fifo_full_i/fifo_empty_i are not used for decisions.
- Round-robin write arbitration:
  - Search starts at pointer p and takes the first k with req_i[k].
  - On accept of k, p becomes (k+1) mod N_REQ; otherwise p is unchanged.
- FSM (at most one grant per cycle, write or read):
  - IDLE:
    - Write wins if a write is legal and any req is set; go to WRITE, burst count=1.
    - Else a legal read is granted; go to READ.
    - Else stay in IDLE.
  - WRITE:
    - If a read is legal and pending and burst count==WR_BURST, grant the read; go to READ.
    - Else, if a write is legal and requested, grant the write and increment burst count (saturating).
    - Else, if a read is legal, grant the read; go to READ.
    - Else go to IDLE.
  - READ:
    - If a write is legal and requested, grant the write; go to WRITE, burst count=1.
    - Else, if a read is legal, grant the read.
    - Else go to IDLE.
- Pipeline:
  - Accept at edge t drives fifo_wr_en_o/fifo_wdata_o (or fifo_rd_en_o) high for cycle t..t+1; they are 0 otherwise.
  - Reads: rd_valid_o is high in the cycle after fifo_rd_en_o, i.e. 2 cycles after accept.
- Boundaries:
  - cnt==DEPTH: gnt_o=0 even with requests.
  - cnt==0: rd_gnt_o=0.
  - Simultaneous full write and read request: handled per the FSM.
  - cnt wraps are impossible by construction.
  - Reset mid-burst: in-flight commands are dropped; rd_valid_o is suppressed.

Optional Feature:
- FSCHED_CHECK_EN defined: adds output sync_err_o (sticky, cleared only by reset). It is set when, with no FIFO command in flight, (cnt==DEPTH)!=fifo_full_i or (cnt==0)!=fifo_empty_i.
- Undefined: no port; the flag inputs are unused.

Decomposition:
- Package fifo_sched_pkg: state enum (IDLE, WRITE, READ), level width function, WR_BURST counter width.
- Sub-module rr_arbiter (N_REQ, req, enable, one-hot grant, pointer update on accept).

Test Plan:
- Reset release: fifo_rst_o high 1 cycle after rst_ni rises; no gnt during that cycle; level_o=0.
- req_i=4'b1111 continuously, no reads: grants cycle 0,1,2,3,0..., exactly 16 accepts; gnt_o=0 at level 16; FIFO error_o never 1.
- Fill to 16 with data 0..F, rd_req_i held: 16 reads; rd_data_o sequence 0..F, each 2 cycles after accept; rd_gnt_o=0 at level 0.
- req_i=4'b0001 and rd_req_i held, level 8: pattern of 4 writes then 1 read, repeating; level_o rises by 3 per 5 cycles.
- Assert rst_ni=0 mid-burst: all outputs 0 immediately; level_o=0; no rd_valid_o after release.
- With FSCHED_CHECK_EN, force fifo_full_i=1 at level 3 while idle: sync_err_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO access scheduler: state encoding and
// width helpers for the occupancy and write-burst counters.
package fifo_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ
  } fsched_state_e;

  // Occupancy must be able to represent DEPTH itself, not just DEPTH-1.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int burst_w(input int wr_burst);
    return (wr_burst < 1) ? 1 : $clog2(wr_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_access_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // Two passes: requesters at or above the pointer first, then the wrap-around.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (en_i && !found && req_i[j] && (PW'(j) >= ptr_q)) begin
        gnt_o[j] = 1'b1;
        ptr_d    = PW'((j + 1) % N_REQ);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (en_i && !found && req_i[j] && (PW'(j) < ptr_q)) begin
        gnt_o[j] = 1'b1;
        ptr_d    = PW'((j + 1) % N_REQ);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (|gnt_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fifo_access_sched.sv
// Scheduler in front of one sync FIFO: round-robin writers, bounded-burst reads,
// shadow occupancy. Optional FSCHED_CHECK_EN adds a sticky flag/shadow sync check.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_IDLE  | no grant last cycle; writes preferred over reads
// ST_WRITE | write granted last cycle; burst_q counts the consecutive writes
// ST_READ  | read granted last cycle; a pending write takes the next slot
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 4,
  parameter int WR_BURST = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*WIDTH-1:0]    wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  input  logic                      rd_req_i,
  output logic                      rd_gnt_o,
  output logic                      rd_valid_o,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic                      fifo_rst_o,
  output logic                      fifo_wr_en_o,
  output logic [WIDTH-1:0]          fifo_wdata_o,
  output logic                      fifo_rd_en_o,
  input  logic [WIDTH-1:0]          fifo_rdata_i,
  input  logic                      fifo_full_i,
  input  logic                      fifo_empty_i,
  output logic [level_w(DEPTH)-1:0] level_o
`ifdef FSCHED_CHECK_EN
  ,
  output logic                      sync_err_o
`endif
);

  localparam int LW = level_w(DEPTH);
  localparam int BW = burst_w(WR_BURST);
  localparam logic [LW-1:0] CNT_MAX   = LW'(DEPTH);
  localparam logic [BW-1:0] BURST_MAX = BW'(WR_BURST);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d, burst_inc;
  logic [LW-1:0]    cnt_q;
  logic             fifo_rst_q;
  logic             wr_ok, rd_ok;
  logic             do_wr, do_rd;
  logic [N_REQ-1:0] arb_gnt;
  logic [WIDTH-1:0] wsel;
  logic             fifo_wr_en_q, fifo_rd_en_q, rd_valid_q;
  logic [WIDTH-1:0] fifo_wdata_q;

  // Decisions use only the shadow count; the FIFO's own flags lag by a cycle.
  assign wr_ok = !fifo_rst_q && (cnt_q < CNT_MAX) && (|req_i);
  assign rd_ok = !fifo_rst_q && (cnt_q != '0) && rd_req_i;

  assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);

  always_comb begin
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      ST_WRITE: begin
        if (rd_ok && (burst_q == BURST_MAX)) begin
          do_rd   = 1'b1;
          state_d = ST_READ;
        end else if (wr_ok) begin
          do_wr   = 1'b1;
          burst_d = burst_inc;
        end else if (rd_ok) begin
          do_rd   = 1'b1;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (wr_ok) begin
          do_wr   = 1'b1;
          state_d = ST_WRITE;
          burst_d = BW'(1);
        end else if (rd_ok) begin
          do_rd   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (wr_ok) begin
          do_wr   = 1'b1;
          state_d = ST_WRITE;
          burst_d = BW'(1);
        end else if (rd_ok) begin
          do_rd   = 1'b1;
          state_d = ST_READ;
        end
      end
    endcase
  end

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (req_i),
    .en_i  (do_wr),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    wsel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) wsel = wsel | wdata_i[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_rst_q   <= 1'b1;
      state_q      <= ST_IDLE;
      burst_q      <= '0;
      cnt_q        <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_wdata_q <= '0;
      fifo_rd_en_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      fifo_rst_q   <= 1'b0;
      state_q      <= state_d;
      burst_q      <= burst_d;
      if (do_wr)      cnt_q <= cnt_q + LW'(1);
      else if (do_rd) cnt_q <= cnt_q - LW'(1);
      fifo_wr_en_q <= do_wr;
      fifo_wdata_q <= do_wr ? wsel : '0;
      fifo_rd_en_q <= do_rd;
      rd_valid_q   <= fifo_rd_en_q;
    end
  end

  assign gnt_o        = arb_gnt;
  assign rd_gnt_o     = do_rd;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = fifo_rdata_i;
  assign fifo_rst_o   = fifo_rst_q;
  assign fifo_wr_en_o = fifo_wr_en_q;
  assign fifo_wdata_o = fifo_wdata_q;
  assign fifo_rd_en_o = fifo_rd_en_q;
  assign level_o      = cnt_q;

`ifdef FSCHED_CHECK_EN
  logic sync_err_q;
  logic in_flight;

  // Flags are only comparable once every issued command has landed in the FIFO.
  assign in_flight = fifo_wr_en_q | fifo_rd_en_q | fifo_rst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_err_q <= 1'b0;
    end else if (!in_flight &&
                 (((cnt_q == CNT_MAX) != fifo_full_i) ||
                  ((cnt_q == '0) != fifo_empty_i))) begin
      sync_err_q <= 1'b1;
    end
  end

  assign sync_err_o = sync_err_q;
`else
  logic unused_flags;
  assign unused_flags = fifo_full_i ^ fifo_empty_i;
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched: behavioural FIFO plus a grant-history reference
// model of the scheduling policy, driven with directed and random traffic.
module tb_fifo_access_sched;

  localparam int N_REQ    = 4;
  localparam int DEPTH    = 16;
  localparam int WIDTH    = 4;
  localparam int WR_BURST = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*WIDTH-1:0] wdata_i;
  logic [N_REQ-1:0]       gnt_o;
  logic                   rd_req_i;
  logic                   rd_gnt_o;
  logic                   rd_valid_o;
  logic [WIDTH-1:0]       rd_data_o;
  logic                   fifo_rst_o;
  logic                   fifo_wr_en_o;
  logic [WIDTH-1:0]       fifo_wdata_o;
  logic                   fifo_rd_en_o;
  logic [WIDTH-1:0]       fifo_rdata_i;
  logic                   fifo_full_i;
  logic                   fifo_empty_i;
  logic [4:0]             level_o;
`ifdef FSCHED_CHECK_EN
  logic                   sync_err_o;
`endif

  always #5 clk_i = ~clk_i;

  fifo_access_sched #(
    .N_REQ(N_REQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .WR_BURST(WR_BURST)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .wdata_i(wdata_i),
    .gnt_o(gnt_o),
    .rd_req_i(rd_req_i),
    .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o),
    .fifo_rst_o(fifo_rst_o),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wdata_o(fifo_wdata_o),
    .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_rdata_i(fifo_rdata_i),
    .fifo_full_i(fifo_full_i),
    .fifo_empty_i(fifo_empty_i),
`ifdef FSCHED_CHECK_EN
    .sync_err_o(sync_err_o),
`endif
    .level_o(level_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural sync FIFO with an error counter for illegal commands.
  logic [WIDTH-1:0] fq[$];
  int               f_cnt = 0;
  logic [WIDTH-1:0] f_rdata = '0;
  int               f_errs = 0;
  logic             force_full = 1'b0;

  always @(posedge clk_i) begin
    logic [WIDTH-1:0] tmp;
    if (fifo_rst_o) begin
      fq.delete();
      f_cnt <= 0;
    end else if (fifo_wr_en_o) begin
      if (fq.size() >= DEPTH) f_errs++;
      else fq.push_back(fifo_wdata_o);
      f_cnt <= fq.size();
    end else if (fifo_rd_en_o) begin
      if (fq.size() == 0) f_errs++;
      else begin
        tmp = fq.pop_front();
        f_rdata <= tmp;
      end
      f_cnt <= fq.size();
    end
  end

  assign fifo_full_i  = (f_cnt == DEPTH) | force_full;
  assign fifo_empty_i = (f_cnt == 0);
  assign fifo_rdata_i = f_rdata;

  // Reference model: policy expressed over grant history, not FSM states.
  int               m_cnt, m_ptr, m_streak;
  bit               m_last_wr, m_rst_hold;
  logic [WIDTH-1:0] m_q[$];
  bit               p_wr, p_rd, p2_rd;
  logic [WIDTH-1:0] p_wd, p_rdd, p2_rdd;
  int               obs_k;
  bit               obs_rd, obs_valid;
  logic [WIDTH-1:0] obs_data;

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_streak = 0; m_last_wr = 0; m_rst_hold = 1;
    m_q.delete();
    p_wr = 0; p_rd = 0; p2_rd = 0; p_wd = '0; p_rdd = '0; p2_rdd = '0;
  endtask

  // One cycle: drive after the falling edge, check, advance the model.
  task automatic step(input logic [N_REQ-1:0] rq, input logic rr,
                      input logic [N_REQ*WIDTH-1:0] wd);
    int               ek;
    bit               erd, wr_ok, rd_ok;
    logic [N_REQ-1:0] egnt;
    logic [WIDTH-1:0] ewd;
    req_i = rq; rd_req_i = rr; wdata_i = wd;
    #1;
    wr_ok = !m_rst_hold && (m_cnt < DEPTH) && (rq != '0);
    rd_ok = !m_rst_hold && (m_cnt > 0) && rr;
    ek = -1; erd = 0;
    if (wr_ok && !(rd_ok && m_last_wr && m_streak >= WR_BURST)) begin
      for (int i = 0; i < N_REQ; i++) begin
        int c;
        c = (m_ptr + i) % N_REQ;
        if (ek < 0 && rq[c]) ek = c;
      end
    end else if (rd_ok) begin
      erd = 1;
    end
    egnt = '0;
    if (ek >= 0) egnt[ek] = 1'b1;

    n_cmp++; if (gnt_o !== egnt) begin n_err++;
      $display("FAIL gnt_o: got %b required %b t=%0t", gnt_o, egnt, $time); end
    n_cmp++; if (rd_gnt_o !== erd) begin n_err++;
      $display("FAIL rd_gnt_o: got %b required %b t=%0t", rd_gnt_o, erd, $time); end
    n_cmp++; if (level_o !== 5'(m_cnt)) begin n_err++;
      $display("FAIL level_o: got %0d required %0d t=%0t", level_o, m_cnt, $time); end
    n_cmp++; if (fifo_rst_o !== m_rst_hold) begin n_err++;
      $display("FAIL fifo_rst_o: got %b required %b t=%0t", fifo_rst_o, m_rst_hold, $time); end
    n_cmp++; if (fifo_wr_en_o !== p_wr) begin n_err++;
      $display("FAIL fifo_wr_en_o: got %b required %b t=%0t", fifo_wr_en_o, p_wr, $time); end
    if (p_wr) begin
      n_cmp++; if (fifo_wdata_o !== p_wd) begin n_err++;
        $display("FAIL fifo_wdata_o: got %h required %h t=%0t", fifo_wdata_o, p_wd, $time); end
    end
    n_cmp++; if (fifo_rd_en_o !== p_rd) begin n_err++;
      $display("FAIL fifo_rd_en_o: got %b required %b t=%0t", fifo_rd_en_o, p_rd, $time); end
    n_cmp++; if (rd_valid_o !== p2_rd) begin n_err++;
      $display("FAIL rd_valid_o: got %b required %b t=%0t", rd_valid_o, p2_rd, $time); end
    if (p2_rd) begin
      n_cmp++; if (rd_data_o !== p2_rdd) begin n_err++;
        $display("FAIL rd_data_o: got %h required %h t=%0t", rd_data_o, p2_rdd, $time); end
    end

    obs_k = -1;
    for (int i = 0; i < N_REQ; i++) if (gnt_o[i] === 1'b1) obs_k = i;
    obs_rd = rd_gnt_o; obs_valid = rd_valid_o; obs_data = rd_data_o;

    p2_rd = p_rd; p2_rdd = p_rdd;
    p_wr = (ek >= 0); p_rd = erd;
    if (ek >= 0) begin
      ewd = wd[ek*WIDTH +: WIDTH];
      p_wd = ewd;
      m_q.push_back(ewd);
      m_cnt++;
      m_ptr = (ek + 1) % N_REQ;
      m_streak++;
      m_last_wr = 1;
    end else begin
      m_last_wr = 0;
      m_streak = 0;
      if (erd) begin
        p_rdd = m_q.pop_front();
        m_cnt--;
      end
    end
    m_rst_hold = 0;
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    #2 rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = '0; rd_req_i = 1'b0; wdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++; if (fifo_rst_o !== 1'b1) begin n_err++;
      $display("FAIL reset_fifo_rst: got %b required 1", fifo_rst_o); end
    n_cmp++; if (level_o !== 5'd0) begin n_err++;
      $display("FAIL reset_level: got %0d required 0", level_o); end
    n_cmp++; if ({fifo_wr_en_o, fifo_rd_en_o, rd_valid_o, fifo_wdata_o} !== '0) begin n_err++;
      $display("FAIL reset_regs: got %b required 0",
               {fifo_wr_en_o, fifo_rd_en_o, rd_valid_o, fifo_wdata_o}); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'hF, 1'b1, 16'hABCD);
  endtask

  task automatic test_fill_rr();
    int acc = 0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a;
      a = acc[3:0];
      step(4'hF, 1'b0, {a, a, a, a});
      if (obs_k >= 0) begin
        n_cmp++; if (obs_k != acc % N_REQ) begin n_err++;
          $display("FAIL rr_order: got %0d required %0d", obs_k, acc % N_REQ); end
        acc++;
      end
    end
    n_cmp++; if (acc != DEPTH) begin n_err++;
      $display("FAIL fill_count: got %0d required %0d", acc, DEPTH); end
  endtask

  task automatic test_drain();
    int n = 0;
    for (int i = 0; i < 22; i++) begin
      step('0, 1'b1, '0);
      if (obs_valid) begin
        logic [3:0] e;
        e = n[3:0];
        n_cmp++; if (obs_data !== e) begin n_err++;
          $display("FAIL drain_data: got %h required %h", obs_data, e); end
        n++;
      end
    end
    n_cmp++; if (n != DEPTH) begin n_err++;
      $display("FAIL drain_count: got %0d required %0d", n, DEPTH); end
  endtask

  task automatic test_burst();
    apply_reset();
    for (int i = 0; i < 9; i++) step(4'b0001, 1'b0, 16'($urandom));
    n_cmp++; if (level_o !== 5'd8) begin n_err++;
      $display("FAIL burst_start_level: got %0d required 8", level_o); end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) begin
        step(4'b0001, 1'b1, 16'($urandom));
        n_cmp++; if (obs_rd !== (i == 0)) begin n_err++;
          $display("FAIL burst_pattern: got rd=%b required rd=%b slot %0d", obs_rd, (i == 0), i); end
      end
      n_cmp++; if (level_o !== 5'(8 + 3 * (w + 1))) begin n_err++;
        $display("FAIL burst_level: got %0d required %0d", level_o, 8 + 3 * (w + 1)); end
    end
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, 16'($urandom));
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int i = 0; i < 30; i++) step(4'($urandom), 1'($urandom), 16'($urandom));
    for (int i = 0; i < 6; i++) step(4'b0011, 1'b0, 16'($urandom));
    step('0, 1'b1, '0);
    #3 rst_ni = 1'b0;
    #1;
    n_cmp++; if ({fifo_wr_en_o, fifo_rd_en_o, rd_valid_o, fifo_wdata_o, gnt_o, rd_gnt_o} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %b required 0",
               {fifo_wr_en_o, fifo_rd_en_o, rd_valid_o, fifo_wdata_o, gnt_o, rd_gnt_o}); end
    n_cmp++; if (level_o !== 5'd0) begin n_err++;
      $display("FAIL midrst_level: got %0d required 0", level_o); end
    n_cmp++; if (fifo_rst_o !== 1'b1) begin n_err++;
      $display("FAIL midrst_fifo_rst: got %b required 1", fifo_rst_o); end
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step('0, 1'b1, '0);
      if (obs_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++;
      $display("FAIL midrst_valid: got %0d pulses required 0", seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 450; i++) begin
      logic [N_REQ-1:0] rq;
      logic             rr;
      rq = 4'($urandom);
      if (i < 150)      rr = ($urandom_range(0, 3) == 0);
      else if (i < 300) begin rr = ($urandom_range(0, 3) != 0); if ($urandom_range(0, 1) == 0) rq = '0; end
      else              rr = 1'($urandom);
      step(rq, rr, 16'($urandom));
    end
    n_cmp++; if (f_errs != 0) begin n_err++;
      $display("FAIL fifo_error: got %0d illegal commands required 0", f_errs); end
  endtask

`ifdef FSCHED_CHECK_EN
  task automatic test_sync_err();
    apply_reset();
    step('0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 16'($urandom));
    for (int i = 0; i < 2; i++) step('0, 1'b0, '0);
    n_cmp++; if (sync_err_o !== 1'b0) begin n_err++;
      $display("FAIL sync_err_clean: got %b required 0", sync_err_o); end
    force_full = 1'b1;
    for (int i = 0; i < 2; i++) step('0, 1'b0, '0);
    n_cmp++; if (sync_err_o !== 1'b1) begin n_err++;
      $display("FAIL sync_err_set: got %b required 1", sync_err_o); end
    force_full = 1'b0;
    for (int i = 0; i < 3; i++) step('0, 1'b0, '0);
    n_cmp++; if (sync_err_o !== 1'b1) begin n_err++;
      $display("FAIL sync_err_sticky: got %b required 1", sync_err_o); end
    apply_reset();
    n_cmp++; if (sync_err_o !== 1'b0) begin n_err++;
      $display("FAIL sync_err_reset: got %b required 0", sync_err_o); end
    step('0, 1'b0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_fill_rr();
    test_drain();
    test_burst();
    test_reset_mid();
    test_random();
`ifdef FSCHED_CHECK_EN
    test_sync_err();
`endif
    n_cmp++; if (f_errs != 0) begin n_err++;
      $display("FAIL fifo_error_final: got %0d illegal commands required 0", f_errs); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
